// File: rtl/acc_cpu_core.sv
// acc_cpu_core
//   Multicycle accumulator CPU core. Owns PC, IR, ACC and the carry flag and
//   runs a FETCH -> DECODE -> (MEM) -> FETCH control loop against one external
//   single-port memory. HLT parks the core in HALT until reset.
//
//   Parameters
//     DATA_W   accumulator / instruction / memory word width
//     OPC_W    opcode field width (>= 4); opcode = IR[DATA_W-1 -: OPC_W]
//     ADDR_W   derived, DATA_W-OPC_W; operand / address width
//     RESET_PC PC value loaded on reset
//
//   Ports
//     clk, reset       rising-edge clock, synchronous active-low reset
//     mem_req/mem_we   access request and direction (1 = write)
//     mem_addr         access address (PC in FETCH, operand in MEM)
//     mem_wdata        write data (ACC)
//     mem_rdata        read data, captured on the completing edge
//     mem_ready        completes the access on the edge where mem_req=1
//     halted           core is in HALT
//     pc_out, acc_out  architectural PC and ACC
//     flags_out        {N, Z, C}
//
//   Handshake: an access completes on the rising edge where mem_req and
//   mem_ready are both 1. Until then the FSM does not advance, so mem_addr,
//   mem_we and mem_wdata are held stable and mem_req stays asserted; only
//   reset can withdraw a pending request.
module acc_cpu_core #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4,
  localparam int ADDR_W = DATA_W - OPC_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic [2:0]        flags_out
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEM    = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDA  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_STA  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_JN   = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(15);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                c_q, c_d;

  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   add_b;
  logic [DATA_W:0]     add_res;
  logic [DATA_W:0]     sub_res;
  logic                z_flag;
  logic                n_flag;

  assign opcode  = ir_q[DATA_W-1 -: OPC_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm_ext = {{OPC_W{1'b0}}, operand};

  // One adder serves ADDI (in DECODE) and ADD (in MEM); the extra top bit
  // is the carry-out. For SUB the top bit of the widened difference is the
  // unsigned borrow.
  assign add_b   = (state_q == S_MEM) ? mem_rdata : imm_ext;
  assign add_res = {1'b0, acc_q} + {1'b0, add_b};
  assign sub_res = {1'b0, acc_q} - {1'b0, mem_rdata};

  assign z_flag = (acc_q == '0);
  assign n_flag = acc_q[DATA_W-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    c_d     = c_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP:  ;
          OP_LDA, OP_STA, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR: state_d = S_MEM;
          OP_LDI:  acc_d = imm_ext;
          OP_ADDI: begin
            acc_d = add_res[DATA_W-1:0];
            c_d   = add_res[DATA_W];
          end
          OP_JMP:  pc_d = operand;
          OP_JZ:   if (z_flag) pc_d = operand;
          OP_JN:   if (n_flag) pc_d = operand;
          OP_SHL: begin
            acc_d = {acc_q[DATA_W-2:0], 1'b0};
            c_d   = acc_q[DATA_W-1];
          end
          OP_SHR: begin
            acc_d = {1'b0, acc_q[DATA_W-1:1]};
            c_d   = acc_q[0];
          end
          OP_HLT:  state_d = S_HALT;
          // Opcodes beyond 15 (wide opcode fields) fall through as NOP.
          default: ;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          case (opcode)
            OP_LDA: acc_d = mem_rdata;
            OP_ADD: begin
              acc_d = add_res[DATA_W-1:0];
              c_d   = add_res[DATA_W];
            end
            OP_SUB: begin
              acc_d = sub_res[DATA_W-1:0];
              c_d   = sub_res[DATA_W];
            end
            OP_AND: begin
              acc_d = acc_q & mem_rdata;
              c_d   = 1'b0;
            end
            OP_OR: begin
              acc_d = acc_q | mem_rdata;
              c_d   = 1'b0;
            end
            OP_XOR: begin
              acc_d = acc_q ^ mem_rdata;
              c_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are gated by reset so that the cycle in which reset is first
  // asserted already withdraws the request and shows the reset values.
  assign mem_req   = reset && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = reset && (state_q == S_MEM) && (opcode == OP_STA);
  assign mem_addr  = (state_q == S_MEM) ? operand : pc_q;
  assign mem_wdata = acc_q;
  assign halted    = reset && (state_q == S_HALT);
  assign pc_out    = reset ? pc_q : RESET_PC;
  assign acc_out   = reset ? acc_q : '0;
  assign flags_out = reset ? {n_flag, z_flag, c_q} : 3'b010;

endmodule

// File: tb/tb_acc_cpu_core.sv
module tb_acc_cpu_core;

  // Access record: {we, addr, wdata, acc, flags}; wdata is zero for reads.
  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic [23:0] acc;
    logic [2:0]  flags;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT0: 16-bit, 4-bit opcode ----------------
  logic        rst0, req0, we0, ready0, halted0;
  logic [11:0] addr0, pc0;
  logic [15:0] wdata0, rdata0, acc0;
  logic [2:0]  flags0;
  logic [15:0] mem0 [0:4095];
  assign rdata0 = mem0[addr0];

  acc_cpu_core #(.DATA_W(16), .OPC_W(4), .RESET_PC(12'h010)) dut0 (
    .clk(clk), .reset(rst0), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_ready(ready0),
    .halted(halted0), .pc_out(pc0), .acc_out(acc0), .flags_out(flags0)
  );

  // ---------------- DUT1: 24-bit, 5-bit opcode ----------------
  logic        rst1, req1, we1, ready1, halted1;
  logic [18:0] addr1, pc1;
  logic [23:0] wdata1, rdata1, acc1;
  logic [2:0]  flags1;
  logic [23:0] mem1 [0:524287];
  assign rdata1 = mem1[addr1];

  acc_cpu_core #(.DATA_W(24), .OPC_W(5), .RESET_PC(19'h40000)) dut1 (
    .clk(clk), .reset(rst1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(ready1),
    .halted(halted1), .pc_out(pc1), .acc_out(acc1), .flags_out(flags1)
  );

  // ---------------- scoreboard ----------------
  ev_t exp_q0[$];
  ev_t exp_q1[$];

  function automatic ev_t mk(input logic we, input logic [23:0] addr,
                             input logic [23:0] wdata, input logic [23:0] acc,
                             input logic [2:0] flags);
    ev_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.acc = acc; e.flags = flags;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cmp_ev(input string name, input ev_t got, input ev_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got we=%0b addr=%0h wdata=%0h acc=%0h flags=%03b expected we=%0b addr=%0h wdata=%0h acc=%0h flags=%03b",
               name, got.we, got.addr, got.wdata, got.acc, got.flags,
               exp.we, exp.addr, exp.wdata, exp.acc, exp.flags);
    end
  endtask

  // Monitors: an access completes on the next rising edge when req and ready
  // are both high with reset released; sampled on the falling edge before it.
  always @(negedge clk) begin
    if (rst0 && req0 && ready0) begin
      ev_t obs;
      obs = mk(we0, 24'(addr0), we0 ? 24'(wdata0) : 24'h0, 24'(acc0), flags0);
      if (exp_q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL trace0 unexpected access: addr=%0h we=%0b", addr0, we0);
      end else begin
        cmp_ev("trace0", obs, exp_q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst1 && req1 && ready1) begin
      ev_t obs;
      obs = mk(we1, 24'(addr1), we1 ? wdata1 : 24'h0, acc1, flags1);
      if (exp_q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL trace1 unexpected access: addr=%0h we=%0b", addr1, we1);
      end else begin
        cmp_ev("trace1", obs, exp_q1.pop_front());
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int t0;
    rst0 = 1'b0; rst1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;

    for (int i = 0; i < 4096; i++) mem0[i] = 16'h0000;
    for (int i = 0; i < 524288; i++) mem1[i] = 24'h000000;

    // DUT0 program
    mem0[12'h010] = 16'h8FFF; // LDI 0xFFF
    mem0[12'h011] = 16'h9001; // ADDI 1
    mem0[12'h012] = 16'h3100; // ADD [100]
    mem0[12'h013] = 16'h2101; // STA 101
    mem0[12'h014] = 16'h4102; // SUB [102]
    mem0[12'h015] = 16'h2103; // STA 103
    mem0[12'h016] = 16'h8000; // LDI 0
    mem0[12'h017] = 16'hB030; // JZ 030
    mem0[12'h030] = 16'hC040; // JN 040 (not taken)
    mem0[12'h031] = 16'h8123; // LDI 0x123
    mem0[12'h032] = 16'hD000; // SHL
    mem0[12'h033] = 16'hE000; // SHR
    mem0[12'h034] = 16'h7104; // XOR [104]
    mem0[12'h035] = 16'hD000; // SHL
    mem0[12'h036] = 16'hE000; // SHR
    mem0[12'h037] = 16'h5105; // AND [105]
    mem0[12'h038] = 16'h6106; // OR [106]
    mem0[12'h039] = 16'h0000; // NOP
    mem0[12'h03A] = 16'hAFFF; // JMP FFF
    mem0[12'hFFF] = 16'h1107; // LDA [107]
    mem0[12'h000] = 16'h2020; // STA 020
    mem0[12'h001] = 16'hF000; // HLT
    mem0[12'h040] = 16'hF000; // HLT (only reached on a wrong JN)
    mem0[12'h100] = 16'hF000;
    mem0[12'h102] = 16'h0001;
    mem0[12'h104] = 16'hFFFF;
    mem0[12'h105] = 16'h0F0F;
    mem0[12'h106] = 16'h1000;
    mem0[12'h107] = 16'h1234;

    // DUT1 program (opcode in bits [23:19])
    mem1[19'h40000] = 24'h400FFF; // LDI 0xFFF
    mem1[19'h40001] = 24'h480001; // ADDI 1
    mem1[19'h40002] = 24'h180100; // ADD [100]
    mem1[19'h40003] = 24'hF92345; // opcode 0x1F -> NOP
    mem1[19'h40004] = 24'h47FFFF; // LDI 0x7FFFF
    mem1[19'h40005] = 24'h17FFFE; // STA 7FFFE
    mem1[19'h40006] = 24'h57FFFF; // JMP 7FFFF
    mem1[19'h7FFFF] = 24'h680000; // SHL
    mem1[19'h00000] = 24'h780000; // HLT
    mem1[19'h00100] = 24'hFFF000;

    // ---- reset and first fetch ----
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_req",    32'(req0),    32'h0);
      check("rst_halted", 32'(halted0), 32'h0);
      check("rst_acc",    32'(acc0),    32'h0);
      check("rst_flags",  32'(flags0),  32'h2);
      check("rst_pc",     32'(pc0),     32'h010);
    end

    exp_q0.push_back(mk(0, 24'h010, 0, 24'h0000, 3'b010));
    exp_q0.push_back(mk(0, 24'h011, 0, 24'h0FFF, 3'b000));
    exp_q0.push_back(mk(0, 24'h012, 0, 24'h1000, 3'b000));
    exp_q0.push_back(mk(0, 24'h100, 0, 24'h1000, 3'b000));
    exp_q0.push_back(mk(0, 24'h013, 0, 24'h0000, 3'b011));
    exp_q0.push_back(mk(1, 24'h101, 24'h0000, 24'h0000, 3'b011));
    exp_q0.push_back(mk(0, 24'h014, 0, 24'h0000, 3'b011));
    exp_q0.push_back(mk(0, 24'h102, 0, 24'h0000, 3'b011));
    exp_q0.push_back(mk(0, 24'h015, 0, 24'hFFFF, 3'b101));
    exp_q0.push_back(mk(1, 24'h103, 24'hFFFF, 24'hFFFF, 3'b101));
    exp_q0.push_back(mk(0, 24'h016, 0, 24'hFFFF, 3'b101));
    exp_q0.push_back(mk(0, 24'h017, 0, 24'h0000, 3'b011));
    exp_q0.push_back(mk(0, 24'h030, 0, 24'h0000, 3'b011));
    exp_q0.push_back(mk(0, 24'h031, 0, 24'h0000, 3'b011));
    exp_q0.push_back(mk(0, 24'h032, 0, 24'h0123, 3'b001));
    exp_q0.push_back(mk(0, 24'h033, 0, 24'h0246, 3'b000));
    exp_q0.push_back(mk(0, 24'h034, 0, 24'h0123, 3'b000));
    exp_q0.push_back(mk(0, 24'h104, 0, 24'h0123, 3'b000));
    exp_q0.push_back(mk(0, 24'h035, 0, 24'hFEDC, 3'b100));
    exp_q0.push_back(mk(0, 24'h036, 0, 24'hFDB8, 3'b101));
    exp_q0.push_back(mk(0, 24'h037, 0, 24'h7EDC, 3'b000));
    exp_q0.push_back(mk(0, 24'h105, 0, 24'h7EDC, 3'b000));
    exp_q0.push_back(mk(0, 24'h038, 0, 24'h0E0C, 3'b000));
    exp_q0.push_back(mk(0, 24'h106, 0, 24'h0E0C, 3'b000));
    exp_q0.push_back(mk(0, 24'h039, 0, 24'h1E0C, 3'b000));
    exp_q0.push_back(mk(0, 24'h03A, 0, 24'h1E0C, 3'b000));
    exp_q0.push_back(mk(0, 24'hFFF, 0, 24'h1E0C, 3'b000));
    exp_q0.push_back(mk(0, 24'h107, 0, 24'h1E0C, 3'b000));
    exp_q0.push_back(mk(0, 24'h000, 0, 24'h1234, 3'b000));
    exp_q0.push_back(mk(1, 24'h020, 24'h1234, 24'h1234, 3'b000));
    exp_q0.push_back(mk(0, 24'h001, 0, 24'h1234, 3'b000));

    rst0 = 1'b1;
    #1;
    check("first_fetch_req",  32'(req0),  32'h1);
    check("first_fetch_addr", 32'(addr0), 32'h010);
    check("first_fetch_we",   32'(we0),   32'h0);
    check("first_fetch_acc",  32'(acc0),  32'h0);
    check("first_fetch_flags", 32'(flags0), 32'h2);

    // ---- wait states on STA 020 (fetch at 000) ----
    n = 0;
    while (!(req0 && !we0 && addr0 == 12'h000) && n < 200) begin tick(); n++; end
    check("sta_fetch_seen", 32'(n < 200), 32'h1);
    t0 = cyc;
    ready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_fetch_req",  32'(req0),  32'h1);
      check("wait_fetch_addr", 32'(addr0), 32'h000);
      check("wait_fetch_we",   32'(we0),   32'h0);
      tick();
    end
    ready0 = 1'b1;
    n = 0;
    while (!(req0 && we0) && n < 20) begin tick(); n++; end
    check("sta_mem_seen", 32'(n < 20), 32'h1);
    ready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_mem_req",   32'(req0),   32'h1);
      check("wait_mem_addr",  32'(addr0),  32'h020);
      check("wait_mem_we",    32'(we0),    32'h1);
      check("wait_mem_wdata", 32'(wdata0), 32'h1234);
      tick();
    end
    ready0 = 1'b1;
    n = 0;
    while (!(req0 && !we0 && addr0 == 12'h001) && n < 20) begin tick(); n++; end
    check("sta_cycles", 32'(cyc - t0), 32'd9);

    // ---- halt ----
    n = 0;
    while (!halted0 && n < 50) begin tick(); n++; end
    check("halt_seen", 32'(halted0), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_req",    32'(req0),    32'h0);
      check("halt_flag",   32'(halted0), 32'h1);
      check("halt_pc",     32'(pc0),     32'h002);
      check("halt_acc",    32'(acc0),    32'h1234);
    end

    // ---- reset mid-access on LDA ----
    rst0 = 1'b0;
    tick();
    check("rst2_req", 32'(req0), 32'h0);
    mem0[12'h010] = 16'h1108; // LDA [108]
    mem0[12'h011] = 16'hF000; // HLT
    mem0[12'h108] = 16'h5A5A;
    exp_q0.push_back(mk(0, 24'h010, 0, 24'h0000, 3'b010));
    exp_q0.push_back(mk(0, 24'h010, 0, 24'h0000, 3'b010));
    exp_q0.push_back(mk(0, 24'h108, 0, 24'h0000, 3'b010));
    exp_q0.push_back(mk(0, 24'h011, 0, 24'h5A5A, 3'b000));
    rst0 = 1'b1;
    #1;
    n = 0;
    while (!(req0 && !we0 && addr0 == 12'h108) && n < 20) begin tick(); n++; end
    check("lda_mem_seen", 32'(n < 20), 32'h1);
    ready0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("lda_wait_req",  32'(req0),  32'h1);
      check("lda_wait_addr", 32'(addr0), 32'h108);
    end
    rst0 = 1'b0;
    ready0 = 1'b1;
    #1;
    check("midrst_req",   32'(req0),    32'h0);
    check("midrst_acc",   32'(acc0),    32'h0);
    check("midrst_pc",    32'(pc0),     32'h010);
    check("midrst_flags", 32'(flags0),  32'h2);
    check("midrst_halt",  32'(halted0), 32'h0);
    tick();
    rst0 = 1'b1;
    #1;
    check("refetch_req",  32'(req0),  32'h1);
    check("refetch_addr", 32'(addr0), 32'h010);
    check("refetch_we",   32'(we0),   32'h0);
    check("refetch_acc",  32'(acc0),  32'h0);
    n = 0;
    while (!halted0 && n < 50) begin tick(); n++; end
    check("rerun_halt", 32'(halted0), 32'h1);
    check("rerun_acc",  32'(acc0),    32'h5A5A);
    check("rerun_pc",   32'(pc0),     32'h012);

    // ---- 24-bit / 5-bit opcode core, zero-wait ----
    exp_q1.push_back(mk(0, 24'h40000, 0, 24'h000000, 3'b010));
    exp_q1.push_back(mk(0, 24'h40001, 0, 24'h000FFF, 3'b000));
    exp_q1.push_back(mk(0, 24'h40002, 0, 24'h001000, 3'b000));
    exp_q1.push_back(mk(0, 24'h00100, 0, 24'h001000, 3'b000));
    exp_q1.push_back(mk(0, 24'h40003, 0, 24'h000000, 3'b011));
    exp_q1.push_back(mk(0, 24'h40004, 0, 24'h000000, 3'b011));
    exp_q1.push_back(mk(0, 24'h40005, 0, 24'h07FFFF, 3'b001));
    exp_q1.push_back(mk(1, 24'h7FFFE, 24'h07FFFF, 24'h07FFFF, 3'b001));
    exp_q1.push_back(mk(0, 24'h40006, 0, 24'h07FFFF, 3'b001));
    exp_q1.push_back(mk(0, 24'h7FFFF, 0, 24'h07FFFF, 3'b001));
    exp_q1.push_back(mk(0, 24'h00000, 0, 24'h0FFFFE, 3'b000));
    tick();
    check("w_rst_req", 32'(req1), 32'h0);
    check("w_rst_pc",  32'(pc1),  32'h40000);
    rst1 = 1'b1;
    #1;
    check("w_first_addr", 32'(addr1), 32'h40000);
    n = 0;
    while (!halted1 && n < 100) begin tick(); n++; end
    check("w_halt_cycles", 32'(n), 32'd20);
    check("w_halt_pc",     32'(pc1),    32'h00001);
    check("w_halt_acc",    32'(acc1),   32'h0FFFFE);
    check("w_halt_flags",  32'(flags1), 32'h0);
    tick();
    check("w_halt_req",    32'(req1),   32'h0);

    check("trace0_drained", 32'(exp_q0.size()), 32'h0);
    check("trace1_drained", 32'(exp_q1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised multicycle accumulator processor core: the next generation of the team's 16-bit accumulator CPU. Data width, opcode width and reset vector are configurable; the core uses a ready/request external memory handshake with wait states, condition flags, conditional branches, shifts and halt. The core owns PC/IR/ACC/carry and the control FSM. It connects to any single-port memory or bus adapter through the `mem_*` ports.

## Interface
- `DATA_W`, 16: accumulator, instruction and memory word width.
- `OPC_W`, 4: opcode field width; must be ≥ 4. `ADDR_W` = `DATA_W`−`OPC_W` is derived and not overridable.
- `RESET_PC`, 0: PC value loaded at reset; `ADDR_W` bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr` out `ADDR_W`: access address.
- `mem_wdata` out `DATA_W`: write data (ACC).
- `mem_rdata` in `DATA_W`: read data, sampled on the edge where `mem_ready`=1.
- `mem_ready` in 1: access completes on the rising edge where `mem_req`&&`mem_ready`. May be combinational (zero-wait).
- `halted` out 1: core is in HALT.
- `pc_out` out `ADDR_W`: current PC.
- `acc_out` out `DATA_W`: current ACC.
- `flags_out` out 3: {N, Z, C}.

## Operation
- Instruction word: opcode = bits [DATA_W-1 -: OPC_W]; operand = low `ADDR_W` bits. Immediates are zero-extended to `DATA_W`.
- Opcodes:
  - 0 NOP.
  - 1 LDA a: ACC=M[a].
  - 2 STA a: M[a]=ACC.
  - 3 ADD a.
  - 4 SUB a: ACC−M[a].
  - 5 AND a.
  - 6 OR a.
  - 7 XOR a.
  - 8 LDI i.
  - 9 ADDI i.
  - A JMP a.
  - B JZ a.
  - C JN a.
  - D SHL.
  - E SHR (logical).
  - F HLT.
  - Opcodes > 15 (when `OPC_W`>4) execute as NOP.
- Flags:
  - Z = (ACC==0) and N = ACC[MSB]. Both are combinational from ACC.
  - C is a register:
    - ADD/ADDI: carry-out.
    - SUB: borrow (1 when ACC < M[a], unsigned).
    - SHL: old ACC[MSB]; SHR: old ACC[0].
    - AND/OR/XOR clear C.
    - All other opcodes leave C unchanged.
- Arithmetic is modulo 2^`DATA_W`. PC increments modulo 2^`ADDR_W`, so 2^`ADDR_W`−1 wraps to 0.
- FSM states:
  - FETCH:
    - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
    - On ready: IR←`mem_rdata`, PC←PC+1, go to DECODE.
  - DECODE (one cycle):
    - Register ops (NOP, LDI, ADDI, SHL, SHR) update ACC/C and go to FETCH.
    - JMP loads PC←a and goes to FETCH.
    - JZ/JN load PC←a if Z/N is set, otherwise PC is unchanged; then go to FETCH.
    - HLT goes to HALT.
    - Opcodes 1–7 go to MEM.
  - MEM:
    - Drives `mem_req`=1, `mem_addr`=operand, `mem_we`=(opcode==STA), `mem_wdata`=ACC.
    - On ready: loads/ALU ops write ACC (and C), then go to FETCH.
  - HALT:
    - `halted`=1 and `mem_req`=0.
    - The core stays in HALT until reset; no further state changes.
- Handshake rules:
  - While `mem_req`=1 and `mem_ready`=0, `mem_addr`, `mem_we` and `mem_wdata` are held stable.
  - The FSM does not advance.
  - `mem_req` is never dropped before completion, except by reset.

## Timing
- Reset (`reset`=0 at an edge):
  - State←FETCH, PC←`RESET_PC`, IR←0, ACC←0, C←0.
  - While `reset`=0, `mem_req` is gated to 0; `halted`=0, `acc_out`=0, `flags_out`=3'b010, `pc_out`=`RESET_PC`.
  - Reset overrides every state. An in-flight access is abandoned mid-wait, and a `mem_ready` arriving in that cycle is ignored.
- Cycle counts with zero-wait memory (`mem_ready` tied 1):
  - Register/branch ops take 2 cycles (FETCH, DECODE).
  - Memory ops take 3 cycles (FETCH, DECODE, MEM).
  - Each wait cycle on `mem_ready` adds 1 cycle to the phase it occurs in.
- The first fetch request appears in the first cycle with `reset`=1.
- ACC/C/PC updates become visible on the outputs in the cycle after the completing edge.
- A STA write occurs on the edge where `mem_req`&&`mem_we`&&`mem_ready`.
- The STA write is exactly one write per instruction. The core never issues duplicate writes.

## Test plan
- Reset and first fetch:
  - Stimulus: `reset`=0 for 2 cycles with `RESET_PC`=0x010, then release.
  - Required: `mem_req`=0 during reset; then `mem_req`=1, `mem_addr`=0x010, `mem_we`=0; `acc_out`=0, `flags_out`=010.
- Arithmetic/flags:
  - Stimulus: program LDI 0xFFF, ADDI 0x001, ADD [M=0xF000] with `DATA_W`=16.
  - Required: ACC=0x0FFF → 0x1000 (C=0) → 0x0000 with C=1, Z=1.
  - Required: SUB of 0x0001 from 0 gives 0xFFFF, C=1, N=1.
- Branches:
  - Stimulus: JZ taken with Z=1.
  - Required: PC=target. JN not taken with N=0: PC=PC+1. JMP to 0xFFF then a fetch at 0xFFF: the next PC wraps to 0x000.
- Wait states:
  - Stimulus: `mem_ready` low for 3 cycles during the FETCH and MEM of STA 0x020 with ACC=0x1234.
  - Required: `mem_addr`/`mem_we`/`mem_wdata` are stable throughout the wait, the instruction takes 2+3+1+3=9 cycles, and there is exactly one write of 0x1234 to 0x020.
- Reset mid-access:
  - Stimulus: assert `reset` while in MEM waiting on a LDA.
  - Required: `mem_req` drops in that cycle, ACC=0, and fetch restarts at `RESET_PC`.
- Halt and parametrisation:
  - Stimulus: HLT.
  - Required: `halted`=1, `mem_req` stays 0 for 20+ cycles, and PC/ACC are frozen.
  - Stimulus: repeat the arithmetic test at `DATA_W`=24, `OPC_W`=5.
  - Required: 19-bit addresses, and opcode 0x1F executes as a NOP.
